// File: rtl/lrf_pkg.sv
// Shared types and sizing helpers for the LRF stream masters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lrf_pkg;

   localparam int PIXEL_W = 8;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      STREAM   = 1'b1
   } state_t;

   // Number of output beats that make up one square frame.
   function automatic int beats_per_image(input int image_dim, input int pixels_per_beat);
      return (image_dim * image_dim) / pixels_per_beat;
   endfunction

   // Counter width able to index 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lrf_axis_skid.sv
// Two-entry registered output buffer for AXI4-Stream masters; head entry drives m_axis directly.
// Latency: a push is visible on m_axis the next cycle when the buffer was empty.
// Backpressure: occupancy is exported so the producer stops pushing at 2; tdata/tlast/tuser hold while stalled.
// Ports: push_* (producer side), occupancy (0..2), m_axis_* (stream side).
// Optional: LRF_STREAMER_TUSER_EN adds push_user / m_axis_tuser.
module lrf_axis_skid
   import lrf_pkg::*;
#(
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_last,
`ifdef LRF_STREAMER_TUSER_EN
   input  logic              push_user,
`endif
   input  logic              push_valid,
   output logic [1:0]        occupancy,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
`ifdef LRF_STREAMER_TUSER_EN
   output logic              m_axis_tuser,
`endif
   input  logic              m_axis_tready
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
`ifdef LRF_STREAMER_TUSER_EN
      logic              user;
`endif
   } entry_t;

   entry_t head;
   entry_t tail;
   entry_t push_ent;
   logic   pop;

   always_comb begin
      push_ent      = '0;
      push_ent.data = push_data;
      push_ent.last = push_last;
`ifdef LRF_STREAMER_TUSER_EN
      push_ent.user = push_user;
`endif
   end

   assign pop = m_axis_tvalid & m_axis_tready;

   // Outputs come straight from the head register: no path from tready.
   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= 2'd0;
      end else begin
         unique case ({push_valid, pop})
            2'b10: begin
               if (occupancy == 2'd0) begin
                  head      <= push_ent;
                  occupancy <= 2'd1;
               end else if (occupancy == 2'd1) begin
                  tail      <= push_ent;
                  occupancy <= 2'd2;
               end
            end
            2'b01: begin
               head      <= tail;
               occupancy <= occupancy - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; new entry lands behind whatever remains.
               if (occupancy == 2'd1) begin
                  head <= push_ent;
               end else begin
                  head <= tail;
                  tail <= push_ent;
               end
            end
            default: ;
         endcase
      end
   end

   assign m_axis_tvalid = (occupancy != 2'd0);
   assign m_axis_tdata  = head.data;
   assign m_axis_tlast  = head.last;
`ifdef LRF_STREAMER_TUSER_EN
   assign m_axis_tuser  = head.user;
`endif

endmodule

// File: rtl/lrf_frame_streamer.sv
// Packs 8-bit pixels into PIXELS_PER_BEAT-wide beats and streams IMAGE_DIM^2 frames with tlast; tracks sof alignment.
// Latency: a beat appears on m_axis the cycle after its last pixel is accepted (buffer empty).
// Backpressure: pix_ready drops only when the beat-completing pixel arrives with a full 2-entry buffer.
// Ports: m_axis_aclk/m_axis_areset (sync, active-high), pix_* input port, m_axis_* master, frame_cnt, sync_err.
// Optional: LRF_STREAMER_TUSER_EN adds m_axis_tuser, high on beat 0 of each frame.
module lrf_frame_streamer
   import lrf_pkg::*;
#(
   parameter int PIXELS_PER_BEAT = 16,
   parameter int IMAGE_DIM       = 512,
   parameter int N_FUSE_COUNT    = 4,
   parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
   input  logic                    m_axis_aclk,
   input  logic                    m_axis_areset,
   input  logic [PIXEL_W-1:0]      pix_data,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   input  logic                    pix_sof,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
`ifdef LRF_STREAMER_TUSER_EN
   output logic                    m_axis_tuser,
`endif
   output logic [N_FUSE_COUNT-1:0] frame_cnt,
   output logic                    sync_err
);

   localparam int P   = PIXELS_PER_BEAT;
   localparam int BPI = beats_per_image(IMAGE_DIM, PIXELS_PER_BEAT);
   localparam int PCW = cnt_width(P);
   localparam int BCW = cnt_width(BPI);

   state_t                  state;
   logic [PCW-1:0]          pix_cnt;
   logic [BCW-1:0]          beat_cnt;
   // Pixels 0..P-2 of the beat in progress; pixel P-1 goes straight into the push.
   logic [DATA_WIDTH-9:0]   partial;
   logic [1:0]              occ;

   logic                    take;
   logic                    at_beat_end;
   logic                    at_frame_start;
   logic                    sof_early;
   logic                    sof_missing;
   logic                    push_valid;
   logic                    push_last;
   logic [DATA_WIDTH-1:0]   push_data;

   assign at_beat_end    = (pix_cnt == PCW'(P - 1));
   assign at_frame_start = (pix_cnt == '0) && (beat_cnt == '0);
   assign pix_ready      = !(at_beat_end && (occ == 2'd2));
   assign take           = pix_valid & pix_ready;

   assign sof_early   = (state == STREAM) && take && pix_sof && !at_frame_start;
   assign sof_missing = (state == STREAM) && take && !pix_sof && at_frame_start;
   // A sof on the beat-completing pixel is always early, so it never pushes.
   assign push_valid  = (state == STREAM) && take && at_beat_end && !pix_sof;
   assign push_last   = (beat_cnt == BCW'(BPI - 1));
   assign push_data   = {pix_data, partial};

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         state     <= WAIT_SOF;
         pix_cnt   <= '0;
         beat_cnt  <= '0;
         partial   <= '0;
         sync_err  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         sync_err <= sof_early | sof_missing;

         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_cnt <= frame_cnt + N_FUSE_COUNT'(1);
         end

         if (take) begin
            unique case (state)
               WAIT_SOF: begin
                  if (pix_sof) begin
                     partial[7:0] <= pix_data;
                     pix_cnt      <= PCW'(1);
                     beat_cnt     <= '0;
                     state        <= STREAM;
                  end
               end
               STREAM: begin
                  if (sof_early) begin
                     // Restart: the partial beat is abandoned, sof pixel is pixel 0.
                     partial[7:0] <= pix_data;
                     pix_cnt      <= PCW'(1);
                     beat_cnt     <= '0;
                  end else if (sof_missing) begin
                     state <= WAIT_SOF;
                  end else if (at_beat_end) begin
                     pix_cnt  <= '0;
                     beat_cnt <= push_last ? '0 : beat_cnt + BCW'(1);
                  end else begin
                     partial[{pix_cnt, 3'b000} +: 8] <= pix_data;
                     pix_cnt <= pix_cnt + PCW'(1);
                  end
               end
               default: state <= WAIT_SOF;
            endcase
         end
      end
   end

`ifdef LRF_STREAMER_TUSER_EN
   logic push_user;
   assign push_user = (beat_cnt == '0);
`endif

   lrf_axis_skid #(
      .DATA_W (DATA_WIDTH)
   ) u_skid (
      .clk           (m_axis_aclk),
      .rst           (m_axis_areset),
      .push_data     (push_data),
      .push_last     (push_last),
`ifdef LRF_STREAMER_TUSER_EN
      .push_user     (push_user),
`endif
      .push_valid    (push_valid),
      .occupancy     (occ),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
`ifdef LRF_STREAMER_TUSER_EN
      .m_axis_tuser  (m_axis_tuser),
`endif
      .m_axis_tready (m_axis_tready)
   );

endmodule

// File: tb/tb_lrf_frame_streamer.sv
// Scoreboard bench for lrf_frame_streamer with IMAGE_DIM=32, 16 pixels per beat (64 beats per frame).
// Stimulus pushes expected beats into a queue; a negedge monitor pops and compares on every handshake.
// Optional: LRF_STREAMER_TUSER_EN also checks m_axis_tuser.
module tb_lrf_frame_streamer;
   import lrf_pkg::*;

   localparam int P    = 16;
   localparam int DIM  = 32;
   localparam int NF   = 4;
   localparam int DW   = 128;
   localparam int BPI  = 64;
   localparam int NPIX = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    pix_data;
   logic          pix_valid;
   logic          pix_ready;
   logic          pix_sof;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
`ifdef LRF_STREAMER_TUSER_EN
   logic          m_axis_tuser;
`endif
   logic [NF-1:0] frame_cnt;
   logic          sync_err;

   always #5 clk = ~clk;

   lrf_frame_streamer #(
      .PIXELS_PER_BEAT (P),
      .IMAGE_DIM       (DIM),
      .N_FUSE_COUNT    (NF),
      .DATA_WIDTH      (DW)
   ) dut (
      .m_axis_aclk   (clk),
      .m_axis_areset (rst),
      .pix_data      (pix_data),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .pix_sof       (pix_sof),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
`ifdef LRF_STREAMER_TUSER_EN
      .m_axis_tuser  (m_axis_tuser),
`endif
      .frame_cnt     (frame_cnt),
      .sync_err      (sync_err)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   sync_pulses = 0;
   int   exp_fc = 0;
   int   tr_mode = 0;
   int   tr_phase = 0;

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   function automatic logic [DW-1:0] beat_val(input int base, input int b);
      logic [DW-1:0] v;
      for (int k = 0; k < P; k++) v[8*k +: 8] = 8'((base + b*P + k) & 255);
      return v;
   endfunction

   task automatic expect_beat(input int base, input int b, input bit last);
      exp_t e;
      e.data = beat_val(base, b);
      e.last = last;
      e.user = (b == 0);
      sb.push_back(e);
   endtask

   // tready pattern: 0 = always high, 1 = high one cycle in three, other = held low.
   always @(posedge clk) begin
      #1;
      case (tr_mode)
         0: m_axis_tready = 1'b1;
         1: begin
            tr_phase = (tr_phase + 1) % 3;
            m_axis_tready = (tr_phase == 0);
         end
         default: m_axis_tready = 1'b0;
      endcase
   end

   // Monitor: compares beats, checks stability under stall, frame_cnt steps and stall cause.
   logic [DW-1:0] prev_data;
   logic          prev_last;
   bit            stalled = 0;
   bit            fc_pending = 0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stalled    = 0;
         fc_pending = 0;
      end else begin
         if (fc_pending) begin
            chk("frame_cnt_step", frame_cnt, exp_fc);
            fc_pending = 0;
         end
         if (stalled) begin
            chk("tvalid_held", m_axis_tvalid, 1);
            chk("tdata_stable", m_axis_tdata, prev_data);
            chk("tlast_stable", m_axis_tlast, prev_last);
         end
         if (sync_err) sync_pulses++;
         if (!pix_ready) begin
            chk("stall_occupancy", dut.occ, 2);
            chk("stall_pix_cnt", dut.pix_cnt, 15);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got data %0h last %b want no beat", m_axis_tdata, m_axis_tlast);
            end else begin
               e = sb.pop_front();
               chk("beat_data", m_axis_tdata, e.data);
               chk("beat_last", m_axis_tlast, e.last);
`ifdef LRF_STREAMER_TUSER_EN
               chk("beat_user", m_axis_tuser, e.user);
`endif
            end
            if (m_axis_tlast) begin
               exp_fc = (exp_fc + 1) % 16;
               fc_pending = 1;
            end
         end
         stalled   = m_axis_tvalid && !m_axis_tready;
         prev_data = m_axis_tdata;
         prev_last = m_axis_tlast;
      end
   end

   task automatic do_reset();
      rst       = 1'b1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      exp_fc = 0;
   endtask

   // Presents one pixel and returns #1 after the edge that accepted it.
   task automatic send_pix(input int d, input bit s);
      bit took;
      int w;
      pix_data  = 8'(d & 255);
      pix_sof   = s;
      pix_valid = 1'b1;
      w = 0;
      took = 0;
      while (!took) begin
         @(negedge clk);
         took = pix_ready;
         @(posedge clk);
         #1;
         if (!took) begin
            w++;
            if (w > 1000) begin
               checks++;
               failures++;
               $display("FAIL pix_accept_timeout: got pix_ready 0 want 1");
               took = 1;
            end
         end
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic send_frame(input int base, input bit lat);
      for (int b = 0; b < BPI; b++) expect_beat(base, b, b == BPI - 1);
      for (int i = 0; i < NPIX; i++) begin
         send_pix(base + i, i == 0);
         if (lat && i == P - 1) chk("first_beat_latency", m_axis_tvalid, 1);
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 5000 && sb.size() != 0; c++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d beats outstanding want 0", sb.size());
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   int s0;

   initial begin
      pix_valid     = 1'b0;
      pix_sof       = 1'b0;
      pix_data      = 8'h00;
      m_axis_tready = 1'b1;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_sync_err", sync_err, 0);
      chk("rst_pix_ready", pix_ready, 1);
      chk("rst_state", dut.state, WAIT_SOF);
`ifdef LRF_STREAMER_TUSER_EN
      chk("rst_tuser", m_axis_tuser, 0);
`endif
      @(posedge clk);
      #1;

      // 1: clean frame, tready high
      s0 = sync_pulses;
      send_frame(0, 1);
      drain();
      chk("s1_frame_cnt", frame_cnt, 1);
      chk("s1_sync_err", sync_pulses - s0, 0);

      // 2: same frame, tready high one cycle in three
      tr_mode = 1;
      s0 = sync_pulses;
      send_frame(0, 0);
      drain();
      tr_mode = 0;
      chk("s2_frame_cnt", frame_cnt, 2);
      chk("s2_sync_err", sync_pulses - s0, 0);

      // 3: five pixels without sof (first one is a missing-sof error), then a frame
      s0 = sync_pulses;
      for (int i = 0; i < 5; i++) send_pix(8'hA0 + i, 0);
      send_frame(0, 0);
      drain();
      chk("s3_frame_cnt", frame_cnt, 3);
      chk("s3_sync_err", sync_pulses - s0, 1);

      // 4: sof again at pixel 200 (beat 12 pixel 8): 12 beats without tlast, then a full frame
      s0 = sync_pulses;
      for (int b = 0; b < 12; b++) expect_beat(8'h40, b, 0);
      for (int i = 0; i < 200; i++) send_pix(8'h40 + i, i == 0);
      send_frame(8'h80, 0);
      drain();
      chk("s4_frame_cnt", frame_cnt, 4);
      chk("s4_sync_err", sync_pulses - s0, 1);

      // 5: 17 back-to-back frames, frame_cnt wraps 15 -> 0 -> 1
      do_reset();
      s0 = sync_pulses;
      for (int f = 0; f < 17; f++) send_frame(f * 7, 0);
      drain();
      chk("s5_frame_cnt", frame_cnt, 1);
      chk("s5_sync_err", sync_pulses - s0, 0);

      // 6: fill the buffer under tready=0, reset mid-frame, then a clean frame
      do_reset();
      tr_mode = 2;
      @(posedge clk);
      #1;
      for (int i = 0; i < 47; i++) send_pix(i, i == 0);
      @(negedge clk);
      chk("s6_pix_ready_full", pix_ready, 0);
      chk("s6_occupancy", dut.occ, 2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      exp_fc = 0;
      @(negedge clk);
      chk("s6_tvalid", m_axis_tvalid, 0);
      chk("s6_state", dut.state, WAIT_SOF);
      chk("s6_pix_ready", pix_ready, 1);
      tr_mode = 0;
      @(posedge clk);
      #1;
      send_frame(8'h33, 1);
      drain();
      chk("s6_frame_cnt", frame_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
